// File: rtl/move_collector.sv
// move_collector
//   Gathers moves from NCH producer FIFOs into a single output FIFO. A producer is
//   served once it has raised its done flag. Grants are fixed priority (MODE=0,
//   highest index wins) or round-robin (MODE=1). One move is transferred per cycle.
//   o_done is raised once every channel has been drained. i_start re-arms collection
//   without flushing the output FIFO.
//
// Ports
//   i_clk        clock
//   i_reset      synchronous, active-high reset
//   i_start      pulse: clear drained flags, move counter and done; re-arm
//   i_ch_done    [NCH]     producer i has finished generating
//   i_ch_empty   [NCH]     producer i FIFO empty
//   i_ch_data    [NCH*DW]  producer FIFO heads (show-ahead), channel i at [i*DW +: DW]
//   o_ch_rden    [NCH]     producer pop strobe, one-hot or zero
//   i_out_rden             consumer pop
//   o_out_data   [DW]      output FIFO head (show-ahead)
//   o_out_empty / o_out_full / o_out_count   output FIFO status
//   o_moves      [CW]      words collected since reset/start, saturating
//   o_done                 all channels drained
module move_collector #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned DW    = 160,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned MODE  = 0,
    parameter int unsigned CW    = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [NCH-1:0]           i_ch_done,
    input  logic [NCH-1:0]           i_ch_empty,
    input  logic [NCH*DW-1:0]        i_ch_data,
    output logic [NCH-1:0]           o_ch_rden,
    input  logic                     i_out_rden,
    output logic [DW-1:0]            o_out_data,
    output logic                     o_out_empty,
    output logic                     o_out_full,
    output logic [$clog2(DEPTH):0]   o_out_count,
    output logic [CW-1:0]            o_moves,
    output logic                     o_done
);

    localparam int unsigned PW   = $clog2(DEPTH);
    localparam int unsigned CntW = PW + 1;
    localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {StScan, StDrain, StDone} state_t;

    state_t             r_state, w_state_d;
    logic [NCH-1:0]     r_drained, w_drained_d;
    logic [CHW-1:0]     r_ptr, w_ptr_d;
    logic [CHW-1:0]     r_last, w_last_d;
    logic [CW-1:0]      r_moves;

    logic [NCH-1:0]     w_elig;
    logic [NCH-1:0]     w_req;
    logic [CHW-1:0]     w_win;
    logic               w_src_empty;
    logic [DW-1:0]      w_src_data;
    logic               w_pop;
    logic               w_rd;

    // Output FIFO storage
    logic [DW-1:0]      r_mem [DEPTH];
    logic [PW-1:0]      r_wptr, r_rptr;
    logic [CntW-1:0]    r_count;

    assign w_elig = i_ch_done & ~r_drained;
    assign w_req  = w_elig & ~i_ch_empty;

    // Mux the granted channel's status and head word.
    always_comb begin
        w_src_empty = 1'b1;
        w_src_data  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (r_ptr == CHW'(i)) begin
                w_src_empty = i_ch_empty[i];
                w_src_data  = i_ch_data[i*DW +: DW];
            end
        end
    end

    // Winner selection among requesting channels.
    always_comb begin : p_win
        int unsigned idx;
        idx   = 0;
        w_win = '0;
        if (MODE == 0) begin
            for (int i = 0; i < NCH; i++) begin
                if (w_req[i]) w_win = CHW'(i);
            end
        end else begin
            // Walk distances NCH..1 from r_last so the nearest request after it wins.
            for (int k = NCH; k >= 1; k--) begin
                idx = 32'(r_last) + unsigned'(k);
                if (idx >= NCH) idx = idx - NCH;
                if ((w_req & (NCH'(1) << idx)) != '0) w_win = CHW'(idx);
            end
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_drained_d = r_drained;
        w_ptr_d     = r_ptr;
        w_last_d    = r_last;
        w_pop       = 1'b0;
        o_ch_rden   = '0;
        if (i_start) begin
            w_state_d   = StScan;
            w_drained_d = '0;
        end else begin
            case (r_state)
                StScan: begin
                    if (&r_drained) begin
                        w_state_d = StDone;
                    end else begin
                        // Empty finished channels are retired in bulk.
                        w_drained_d = r_drained | (w_elig & i_ch_empty);
                        if (|w_req) begin
                            w_ptr_d   = w_win;
                            w_last_d  = w_win;
                            w_state_d = StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (w_src_empty) begin
                        w_drained_d = r_drained | (NCH'(1) << r_ptr);
                        w_state_d   = StScan;
                    end else if (!o_out_full && !i_reset) begin
                        // No pop while reset is held, so no word is lost to the reset.
                        w_pop     = 1'b1;
                        o_ch_rden = NCH'(1) << r_ptr;
                    end
                end
                StDone: begin
                end
                default: w_state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StScan;
            r_drained <= '0;
            r_ptr     <= '0;
            r_last    <= CHW'(NCH - 1);
            r_moves   <= '0;
        end else begin
            r_state   <= w_state_d;
            r_drained <= w_drained_d;
            r_ptr     <= w_ptr_d;
            r_last    <= w_last_d;
            if (i_start) begin
                r_moves <= '0;
            end else if (w_pop && (r_moves != '1)) begin
                r_moves <= r_moves + CW'(1);
            end
        end
    end

    // Output FIFO: status comes from the registered count, before this cycle's read.
    assign o_out_empty = (r_count == '0);
    assign o_out_full  = (r_count == CntW'(DEPTH));
    assign w_rd        = i_out_rden && !o_out_empty;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) r_wptr <= r_wptr + PW'(1);
            if (w_rd)  r_rptr <= r_rptr + PW'(1);
            case ({w_pop, w_rd})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_pop) r_mem[r_wptr] <= w_src_data;
    end

    assign o_out_data  = r_mem[r_rptr];
    assign o_out_count = r_count;
    assign o_moves     = r_moves;
    assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_move_collector.sv
// Directed bench for move_collector. Two instances: u_fp (fixed priority) and
// u_rr (round-robin), both with a 4-deep output FIFO and a 3-bit move counter.
// Producer FIFOs are modelled per instance; pops and consumer reads are logged.
module tb_move_collector;
    localparam int unsigned NCH   = 8;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              start     [2];
    logic [NCH-1:0]    ch_done   [2];
    logic [NCH-1:0]    ch_empty  [2];
    logic [NCH*DW-1:0] ch_data   [2];
    logic [NCH-1:0]    ch_rden   [2];
    logic              out_rden  [2];
    logic [DW-1:0]     out_data  [2];
    logic              out_empty [2];
    logic              out_full  [2];
    logic [2:0]        out_count [2];
    logic [CW-1:0]     moves     [2];
    logic              done      [2];

    // Producer FIFO models
    logic [DW-1:0] pmem [2][NCH][32];
    int            pwr  [2][NCH];
    int            prd  [2][NCH];
    logic          pflush;

    logic [DW-1:0] got0[$];
    logic [DW-1:0] got1[$];
    int            popc0[$];
    int            popc1[$];

    int checks   = 0;
    int failures = 0;

    move_collector #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .MODE(0), .CW(CW)) u_fp (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start[0]),
        .i_ch_done   (ch_done[0]),
        .i_ch_empty  (ch_empty[0]),
        .i_ch_data   (ch_data[0]),
        .o_ch_rden   (ch_rden[0]),
        .i_out_rden  (out_rden[0]),
        .o_out_data  (out_data[0]),
        .o_out_empty (out_empty[0]),
        .o_out_full  (out_full[0]),
        .o_out_count (out_count[0]),
        .o_moves     (moves[0]),
        .o_done      (done[0])
    );

    move_collector #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .MODE(1), .CW(CW)) u_rr (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start[1]),
        .i_ch_done   (ch_done[1]),
        .i_ch_empty  (ch_empty[1]),
        .i_ch_data   (ch_data[1]),
        .o_ch_rden   (ch_rden[1]),
        .i_out_rden  (out_rden[1]),
        .o_out_data  (out_data[1]),
        .o_out_empty (out_empty[1]),
        .o_out_full  (out_full[1]),
        .o_out_count (out_count[1]),
        .o_moves     (moves[1]),
        .o_done      (done[1])
    );

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            ch_empty[d] = '0;
            ch_data[d]  = '0;
            for (int c = 0; c < NCH; c++) begin
                ch_empty[d][c]         = (prd[d][c] == pwr[d][c]);
                ch_data[d][c*DW +: DW] = pmem[d][c][prd[d][c][4:0]];
            end
        end
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                if (pflush) prd[d][c] <= pwr[d][c];
                else if (ch_rden[d][c]) prd[d][c] <= prd[d][c] + 1;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (ch_rden[0][c]) popc0.push_back(c);
            if (ch_rden[1][c]) popc1.push_back(c);
        end
        if (out_rden[0] && !out_empty[0]) got0.push_back(out_data[0]);
        if (out_rden[1] && !out_empty[1]) got1.push_back(out_data[1]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int c, input logic [DW-1:0] w);
        pmem[d][c][pwr[d][c][4:0]] = w;
        pwr[d][c] = pwr[d][c] + 1;
    endtask

    task automatic pulse_start(input int d);
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int budget, output int n);
        n = 0;
        while (!done[d] && n < budget) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (ch_rden[d] !== '0) begin
                failures++; $display("FAIL reset_ch_rden[%0d]: got %0h expected 0", d, ch_rden[d]);
            end
            checks++;
            if (out_empty[d] !== 1'b1) begin
                failures++; $display("FAIL reset_out_empty[%0d]: got %0b expected 1", d, out_empty[d]);
            end
            checks++;
            if (out_full[d] !== 1'b0) begin
                failures++; $display("FAIL reset_out_full[%0d]: got %0b expected 0", d, out_full[d]);
            end
            checks++;
            if (out_count[d] !== 3'd0) begin
                failures++; $display("FAIL reset_out_count[%0d]: got %0d expected 0", d, out_count[d]);
            end
            checks++;
            if (moves[d] !== '0) begin
                failures++; $display("FAIL reset_moves[%0d]: got %0d expected 0", d, moves[d]);
            end
            checks++;
            if (done[d] !== 1'b0) begin
                failures++; $display("FAIL reset_done[%0d]: got %0b expected 0", d, done[d]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        int n;
        int bg;
        int bp;
        logic [DW-1:0] exp_w [5];
        int exp_c [5];
        exp_w = '{16'h7000, 16'h7001, 16'h7002, 16'h2000, 16'h2001};
        exp_c = '{7, 7, 7, 2, 2};
        bg = got0.size();
        bp = popc0.size();
        push(0, 7, 16'h7000); push(0, 7, 16'h7001); push(0, 7, 16'h7002);
        push(0, 2, 16'h2000); push(0, 2, 16'h2001);
        out_rden[0] = 1'b1;
        ch_done[0]  = '1;
        // SCAN, 3 pops, empty, SCAN, 2 pops, empty, SCAN(all drained) -> done visible at 10
        wait_done(0, 40, n);
        checks++;
        if (n != 10) begin
            failures++; $display("FAIL fp_done_latency: got %0d cycles expected 10", n);
        end
        step(); step(); step();
        checks++;
        if (got0.size() != bg + 5) begin
            failures++; $display("FAIL fp_word_count: got %0d expected 5", got0.size() - bg);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (got0[bg+i] !== exp_w[i]) begin
                failures++; $display("FAIL fp_word[%0d]: got %0h expected %0h", i, got0[bg+i], exp_w[i]);
            end
            checks++;
            if (popc0[bp+i] != exp_c[i]) begin
                failures++; $display("FAIL fp_pop_ch[%0d]: got %0d expected %0d", i, popc0[bp+i], exp_c[i]);
            end
        end
        checks++;
        if (moves[0] !== 3'd5) begin
            failures++; $display("FAIL fp_moves: got %0d expected 5", moves[0]);
        end
        checks++;
        if (done[0] !== 1'b1) begin
            failures++; $display("FAIL fp_done: got %0b expected 1", done[0]);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int bp;
        int bg;
        int exp_c [3];
        exp_c = '{0, 3, 5};
        bp = popc1.size();
        bg = got1.size();
        push(1, 0, 16'h0A00); push(1, 3, 16'h3A00); push(1, 5, 16'h5A00);
        out_rden[1] = 1'b1;
        ch_done[1]  = '1;
        wait_done(1, 40, n);
        checks++;
        if (done[1] !== 1'b1) begin
            failures++; $display("FAIL rr_done_first: got %0b expected 1", done[1]);
        end
        step(); step(); step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (popc1[bp+i] != exp_c[i]) begin
                failures++; $display("FAIL rr_grant1[%0d]: got %0d expected %0d", i, popc1[bp+i], exp_c[i]);
            end
        end
        checks++;
        if (got1[bg+1] !== 16'h3A00) begin
            failures++; $display("FAIL rr_word1: got %0h expected 3a00", got1[bg+1]);
        end
        checks++;
        if (moves[1] !== 3'd3) begin
            failures++; $display("FAIL rr_moves1: got %0d expected 3", moves[1]);
        end
        // Refill while in DONE, then re-arm.
        push(1, 0, 16'h0B00); push(1, 3, 16'h3B00); push(1, 5, 16'h5B00);
        pulse_start(1);
        checks++;
        if (done[1] !== 1'b0 || moves[1] !== 3'd0) begin
            failures++;
            $display("FAIL rr_start_clear: got done=%0b moves=%0d expected done=0 moves=0", done[1], moves[1]);
        end
        wait_done(1, 40, n);
        checks++;
        if (done[1] !== 1'b1) begin
            failures++; $display("FAIL rr_done_second: got %0b expected 1", done[1]);
        end
        checks++;
        if (popc1.size() != bp + 6) begin
            failures++; $display("FAIL rr_pop_total: got %0d expected 6", popc1.size() - bp);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (popc1[bp+3+i] != exp_c[i]) begin
                failures++; $display("FAIL rr_grant2[%0d]: got %0d expected %0d", i, popc1[bp+3+i], exp_c[i]);
            end
        end
        checks++;
        if (moves[1] !== 3'd3) begin
            failures++; $display("FAIL rr_moves2: got %0d expected 3", moves[1]);
        end
    endtask

    task automatic test_backpressure();
        int n;
        int bg;
        int bp;
        int over;
        ch_done[0] = '0;
        pulse_start(0);
        out_rden[0] = 1'b0;
        bg = got0.size();
        bp = popc0.size();
        for (int i = 0; i < 10; i++) push(0, 1, 16'h1000 + DW'(i));
        ch_done[0] = '1;
        repeat (8) step();
        checks++;
        if (popc0.size() != bp + 4) begin
            failures++; $display("FAIL bp_stall_pops: got %0d expected 4", popc0.size() - bp);
        end
        checks++;
        if (ch_rden[0] !== '0) begin
            failures++; $display("FAIL bp_stall_rden: got %0h expected 0", ch_rden[0]);
        end
        checks++;
        if (out_full[0] !== 1'b1) begin
            failures++; $display("FAIL bp_full: got %0b expected 1", out_full[0]);
        end
        checks++;
        if (out_count[0] !== 3'd4) begin
            failures++; $display("FAIL bp_count_full: got %0d expected 4", out_count[0]);
        end
        out_rden[0] = 1'b1;
        n = 0;
        over = 0;
        while (got0.size() < bg + 10 && n < 60) begin
            step();
            n++;
            if (out_count[0] > 3'd4) over++;
        end
        checks++;
        if (n != 10) begin
            failures++; $display("FAIL bp_stream_cycles: got %0d expected 10", n);
        end
        checks++;
        if (over != 0) begin
            failures++; $display("FAIL bp_count_bound: got %0d cycles above 4 expected 0", over);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (got0[bg+i] !== 16'h1000 + DW'(i)) begin
                failures++;
                $display("FAIL bp_word[%0d]: got %0h expected %0h", i, got0[bg+i], 16'h1000 + DW'(i));
            end
        end
        wait_done(0, 40, n);
        checks++;
        if (done[0] !== 1'b1) begin
            failures++; $display("FAIL bp_done: got %0b expected 1", done[0]);
        end
    endtask

    task automatic test_late_done();
        int n;
        int bg;
        int bp;
        int bad;
        ch_done[0] = '0;
        pulse_start(0);
        out_rden[0] = 1'b1;
        bg = got0.size();
        bp = popc0.size();
        push(0, 4, 16'h4000); push(0, 4, 16'h4001); push(0, 4, 16'h4002);
        ch_done[0] = 8'hEF;
        bad = 0;
        repeat (20) begin
            step();
            if (ch_rden[0] !== '0 || done[0] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++; $display("FAIL late_idle: got %0d active cycles expected 0", bad);
        end
        checks++;
        if (popc0.size() != bp) begin
            failures++; $display("FAIL late_no_pop: got %0d pops expected 0", popc0.size() - bp);
        end
        ch_done[0] = '1;
        wait_done(0, 40, n);
        checks++;
        if (done[0] !== 1'b1) begin
            failures++; $display("FAIL late_done: got %0b expected 1", done[0]);
        end
        step(); step(); step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got0[bg+i] !== 16'h4000 + DW'(i)) begin
                failures++;
                $display("FAIL late_word[%0d]: got %0h expected %0h", i, got0[bg+i], 16'h4000 + DW'(i));
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int n;
        int bp;
        ch_done[0] = '0;
        pulse_start(0);
        out_rden[0] = 1'b0;
        bp = popc0.size();
        for (int i = 0; i < 6; i++) push(0, 6, 16'h6000 + DW'(i));
        ch_done[0] = '1;
        n = 0;
        while (popc0.size() < bp + 2 && n < 20) begin
            step();
            n++;
        end
        // This cycle carries the third word.
        checks++;
        if (ch_rden[0] !== 8'h40) begin
            failures++; $display("FAIL rst_mid_rden: got %0h expected 40", ch_rden[0]);
        end
        reset = 1'b1;
        ch_done[0] = '0;
        ch_done[1] = '0;
        step();
        reset = 1'b0;
        checks++;
        if (ch_rden[0] !== '0) begin
            failures++; $display("FAIL rst_mid_ch_rden: got %0h expected 0", ch_rden[0]);
        end
        checks++;
        if (out_empty[0] !== 1'b1 || out_count[0] !== 3'd0 || out_full[0] !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_fifo: got empty=%0b count=%0d full=%0b expected empty=1 count=0 full=0",
                     out_empty[0], out_count[0], out_full[0]);
        end
        checks++;
        if (moves[0] !== '0) begin
            failures++; $display("FAIL rst_mid_moves: got %0d expected 0", moves[0]);
        end
        checks++;
        if (done[0] !== 1'b0) begin
            failures++; $display("FAIL rst_mid_done: got %0b expected 0", done[0]);
        end
        pflush = 1'b1;
        step();
        pflush = 1'b0;
    endtask

    task automatic test_saturation();
        int n;
        int bg;
        out_rden[0] = 1'b1;
        bg = got0.size();
        for (int i = 0; i < 10; i++) push(0, 0, 16'h0C00 + DW'(i));
        ch_done[0] = '1;
        wait_done(0, 60, n);
        checks++;
        if (done[0] !== 1'b1) begin
            failures++; $display("FAIL sat_done: got %0b expected 1", done[0]);
        end
        checks++;
        if (moves[0] !== 3'd7) begin
            failures++; $display("FAIL sat_moves: got %0d expected 7", moves[0]);
        end
        step(); step(); step();
        checks++;
        if (got0.size() != bg + 10) begin
            failures++; $display("FAIL sat_words: got %0d expected 10", got0.size() - bg);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        pflush      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start[d]    = 1'b0;
            ch_done[d]  = '0;
            out_rden[d] = 1'b0;
        end
        test_reset();
        test_fixed_priority();
        test_round_robin();
        test_backpressure();
        test_late_done();
        test_reset_mid_drain();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/move_collector.md
# move_collector

Parametrised N-channel move-gathering arbiter for the move-generation array. It drains the per-square (or per-column) move FIFOs of `NCH` producers into one internal output FIFO, once each producer has raised its done flag. Arbitration is fixed-priority or round-robin, and throughput is one move per cycle. It signals completion when every channel has been drained and is re-armable with `start`, so a board position can be re-evaluated without a full reset.

## Interface
- `NCH`, 8: number of producer channels.
- `DW`, 160: move word width.
- `DEPTH`, 64: output FIFO depth in words; must be a power of 2 and ≥ 2.
- `MODE`, 0: 0 = fixed priority, highest index wins; 1 = round-robin, starting after the last granted channel.
- `CW`, 16: width of the collected-move counter.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  pulse; clears drained flags, the counter and `done`, and re-arms collection. Does not flush the output FIFO.
- `ch_done`  in  NCH  producer i has finished generating moves.
- `ch_empty`  in  NCH  producer i FIFO is empty.
- `ch_data`  in  NCH*DW  producer FIFO heads, show-ahead; channel i occupies `[i*DW +: DW]`.
- `ch_rden`  out  NCH  pop strobe, one-hot or zero.
- `out_rden`  in  1  consumer pop.
- `out_data`  out  DW  output FIFO head, show-ahead; valid when `!out_empty`.
- `out_empty`  out  1  output FIFO empty.
- `out_full`  out  1  output FIFO full.
- `out_count`  out  log2(DEPTH)+1  output FIFO occupancy.
- `moves`  out  CW  words collected since reset or `start`; saturates at all-ones.
- `done`  out  1  all channels drained.

## Operation
- State machine has three states: SCAN, DRAIN and DONE. Reset state is SCAN.
- Per-channel `drained[i]` flag; all flags cleared on reset or `start`.
- Eligible channel: `ch_done[i] && !drained[i]`.
- **SCAN**
  - Every eligible channel with `ch_empty[i]=1` has `drained[i]` set this cycle; several channels may be set at once.
  - Among eligible channels with `ch_empty[i]=0`, the winner is selected per `MODE`. The winner's index is registered in `ptr`, and the state goes to DRAIN.
  - If every `drained` bit is 1 at the start of the cycle, the state goes to DONE.
  - No pops occur in SCAN.
- **DRAIN**
  - `ch_rden[ptr] = !ch_empty[ptr] && !out_full`, combinationally.
  - On the same cycle, `ch_data[ptr]` is written to the output FIFO and `moves` increments.
  - If `ch_empty[ptr]=1`, then `drained[ptr]` is set and the state returns to SCAN.
  - `out_full` stalls the drain; no word is lost or duplicated.
- **DONE**
  - `done=1`, `ch_rden=0`.
  - Stays in DONE until `start`, which moves to SCAN.
- `start` is honoured in any state. On `start`, the next state is SCAN with flags cleared, and no pop occurs that cycle.
- Round-robin `last` register holds the most recent grant; it resets to `NCH-1`, so channel 0 is searched first.
- Output FIFO:
  - Write with `out_full=1` is never attempted.
  - `out_rden` with `out_empty=1` is ignored.
  - Simultaneous read and write is allowed at any occupancy, provided the write precondition `!out_full` holds.
  - `full` and `empty` are evaluated from the registered count before the read.
  - Pointers wrap modulo `DEPTH`.

## Timing
- Reset values:
  - `ch_rden`=0, `out_empty`=1, `out_full`=0, `out_count`=0, `moves`=0, `done`=0.
  - State SCAN, pointers 0.
- Arbitration overhead is 1 SCAN cycle per channel grant. After that, a channel with k words drains in k cycles, followed by 1 cycle to observe empty.
- Write-to-visibility: a word popped in cycle t appears on `out_data` and deasserts `out_empty` in cycle t+1.
- `done` rises 2 cycles after the last drained flag is set: the flag registers, then SCAN sees all-ones and goes to DONE, with `done` registered from the state.
- A producer whose `ch_done` drops while it is granted continues to drain until empty. Data ordering within one channel is preserved.
- `reset` overrides `start`.

## Test plan
- **Fixed priority, simultaneous done.** `MODE=0`, NCH=8; ch7 holds 3 words, ch2 holds 2, the rest are empty; all `ch_done` rise together. Required: output order is ch7 w0–w2, then ch2 w0–w1; `moves`=5; `done` high; the 6 empty channels are marked drained in the first SCAN cycle.
- **Round-robin.** `MODE=1`; ch0, ch3 and ch5 each hold 1 word and are done. Required: grants go 0, 3, 5. Re-arm with `start` after refilling; the next grants are again 0, 3, 5, because `last` is not reset by `start`. Round-robin order is checked on the pointer trace.
- **Backpressure.** `DEPTH=4`; ch1 holds 10 words and `out_rden`=0. Required: exactly 4 pops, then `ch_rden`=0 and `out_full`=1. Then hold `out_rden`=1 continuously. Required: all 10 words arrive in order with no gaps beyond the refill latency; `out_count` never exceeds 4.
- **Late done.** ch4 is non-empty but `ch_done`=0 for 20 cycles. Required: no pops from ch4 and `done`=0 during that time. After `ch_done` rises, ch4 drains and `done` rises.
- **Reset mid-drain.** Assert `reset` during the 3rd word of a 6-word drain. Required: the next cycle shows all outputs at reset values, the output FIFO is empty, and `moves`=0.
- **Counter saturation.** `CW=3`; drain 10 words. Required: `moves`=7.
